// File: rtl/fht_defines.sv
// ============================================================================
// Module      : fht_defines
// Description : Shared types and constants for the FHT frame scheduler:
//               the scheduler state enum, RAM port-owner select codes and
//               the WAIT_BUSY timeout length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fht_defines;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    START     = 3'd2,
    WAIT_BUSY = 3'd3,
    RUN       = 3'd4,
    UNLOAD    = 3'd5
  } state_t;

  // RAM port owner codes driven on oSEL
  localparam logic [1:0] SEL_IDLE   = 2'd0;
  localparam logic [1:0] SEL_LOAD   = 2'd1;
  localparam logic [1:0] SEL_FHT    = 2'd2;
  localparam logic [1:0] SEL_UNLOAD = 2'd3;

  // Cycles fht_control gets to drop RDY after the start pulse
  localparam int WAIT_BUSY_MAX = 4;

endpackage

`default_nettype wire

// File: rtl/fht_frame_sched_if.sv
// ============================================================================
// Module      : fht_frame_sched_if
// Description : Stream, fht_control handshake and RAM-port signals of the
//               frame scheduler. master = scheduler, slave = environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fht_frame_sched_if #(
  parameter int A_BIT = 8
);

  logic             iIN_VALID;
  logic             oIN_READY;
  logic             oSTART;
  logic             iFHT_RDY;
  logic [1:0]       oSEL;
  logic [1:0]       oBANK;
  logic [A_BIT-1:0] oADDR;
  logic             oWE;
  logic             oOUT_VALID;
  logic             iOUT_READY;
  logic             oBUSY;
  logic             oERR;

  modport master (
    input  iIN_VALID, iFHT_RDY, iOUT_READY,
    output oIN_READY, oSTART, oSEL, oBANK, oADDR, oWE, oOUT_VALID, oBUSY, oERR
  );

  modport slave (
    output iIN_VALID, iFHT_RDY, iOUT_READY,
    input  oIN_READY, oSTART, oSEL, oBANK, oADDR, oWE, oOUT_VALID, oBUSY, oERR
  );

endinterface

`default_nettype wire

// File: rtl/fht_bank_addr_gen.sv
// ============================================================================
// Module      : fht_bank_addr_gen
// Description : Splits a frame sample index into a 4-way bank select (low
//               two bits) and an in-bank address (remaining bits), so that
//               sample k lands in bank k%4 at address k/4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fht_bank_addr_gen #(
  parameter int A_BIT = 8
) (
  input  logic [A_BIT+1:0] i_cnt,
  output logic [1:0]       o_bank,
  output logic [A_BIT-1:0] o_addr
);

  assign o_bank = i_cnt[1:0];
  assign o_addr = i_cnt[A_BIT+1:2];

endmodule

`default_nettype wire

// File: rtl/fht_frame_sched.sv
// ============================================================================
// Module      : fht_frame_sched
// Description : Frame-level scheduler around fht_control and the 4-bank
//               sample RAM: loads N = 4*2^A_BIT samples, kicks the FHT,
//               watches its RDY handshake, then streams the results out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fht_frame_sched
  import fht_defines::*;
#(
  parameter int A_BIT  = 8,
  parameter int WD_BIT = 16
) (
  input  logic                  iCLK,
  input  logic                  iRESET,
  fht_frame_sched_if.master     bus
);

  localparam int c_CW = A_BIT + 2;
  // Index of the last sample in a frame (N-1) is the all-ones counter value
  localparam logic [c_CW-1:0] c_CNT_LAST = '1;

  state_t            r_state;
  state_t            w_next;
  logic [c_CW-1:0]   r_cnt;         // next sample index to write / read
  logic [c_CW-1:0]   r_held;        // index of the word currently on the read port
  logic              r_issue_done;  // last read address of the frame issued
  logic              r_valid;
  logic [WD_BIT-1:0] r_wd;          // WAIT_BUSY timeout / RUN watchdog
  logic              r_err;

  logic [1:0]        w_sel;
  logic              w_in_ready;
  logic              w_start;
  logic              w_we;
  logic              w_issue;
  logic [c_CW-1:0]   w_addr_src;
  logic [1:0]        w_bank;
  logic [A_BIT-1:0]  w_addr;

  // Next-state decode and per-state output strobes
  always_comb begin
    w_next     = r_state;
    w_sel      = SEL_IDLE;
    w_in_ready = 1'b0;
    w_start    = 1'b0;
    w_we       = 1'b0;
    w_issue    = 1'b0;
    w_addr_src = r_cnt;
    case (r_state)
      IDLE: begin
        if (!r_err) w_next = LOAD;
      end
      LOAD: begin
        w_sel      = SEL_LOAD;
        w_in_ready = 1'b1;
        w_we       = bus.iIN_VALID;
        if (bus.iIN_VALID && (r_cnt == c_CNT_LAST)) w_next = START;
      end
      START: begin
        w_sel   = SEL_FHT;
        w_start = 1'b1;
        w_next  = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        w_sel = SEL_FHT;
        if (!bus.iFHT_RDY)                               w_next = RUN;
        else if (r_wd == WD_BIT'(WAIT_BUSY_MAX - 1))     w_next = IDLE;
      end
      RUN: begin
        w_sel = SEL_FHT;
        if (bus.iFHT_RDY) w_next = UNLOAD;
        else if (&r_wd)   w_next = IDLE;
      end
      UNLOAD: begin
        w_sel   = SEL_UNLOAD;
        w_issue = !r_issue_done && (!r_valid || bus.iOUT_READY);
        // While stalled the read port keeps re-reading the pending word
        w_addr_src = w_issue ? r_cnt : r_held;
        if (r_valid && bus.iOUT_READY && r_issue_done) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State, counters, watchdog, sticky error and output-valid registers
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_held       <= '0;
      r_issue_done <= 1'b0;
      r_valid      <= 1'b0;
      r_wd         <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_next;

      if ((r_state == WAIT_BUSY) || (r_state == RUN)) begin
        r_wd <= (w_next != r_state) ? '0 : r_wd + WD_BIT'(1);
        if (w_next == IDLE) r_err <= 1'b1;
      end else begin
        r_wd <= '0;
      end

      if ((r_state == LOAD) && bus.iIN_VALID) begin
        r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + c_CW'(1);
      end

      if (r_state == UNLOAD) begin
        if (w_issue) begin
          r_held <= r_cnt;
          if (r_cnt == c_CNT_LAST) begin
            r_cnt        <= '0;
            r_issue_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_CW'(1);
          end
        end
        if (!r_valid || bus.iOUT_READY) r_valid <= w_issue;
        if (w_next == IDLE) begin
          r_held       <= '0;
          r_issue_done <= 1'b0;
          r_valid      <= 1'b0;
        end
      end
    end
  end

  fht_bank_addr_gen #(
    .A_BIT (A_BIT)
  ) u_addr_gen (
    .i_cnt  (w_addr_src),
    .o_bank (w_bank),
    .o_addr (w_addr)
  );

  assign bus.oIN_READY  = w_in_ready;
  assign bus.oSTART     = w_start;
  assign bus.oSEL       = w_sel;
  assign bus.oBANK      = w_bank;
  assign bus.oADDR      = w_addr;
  assign bus.oWE        = w_we;
  assign bus.oOUT_VALID = r_valid;
  assign bus.oBUSY      = (r_state != IDLE);
  assign bus.oERR       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fht_frame_sched.sv
// ============================================================================
// Module      : tb_fht_frame_sched
// Description : Scoreboard bench for fht_frame_sched with A_BIT=2 (N=16).
//               A 4-bank RAM and an fht_control stand-in (RDY handshake only,
//               data passed through unchanged) surround the scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fht_frame_sched;

  localparam int A_BIT = 2;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fht_frame_sched_if #(.A_BIT(A_BIT)) bus ();

  fht_frame_sched #(
    .A_BIT  (A_BIT),
    .WD_BIT (8)
  ) dut (
    .iCLK   (clk),
    .iRESET (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Stimulus knobs
  logic [15:0] in_data  = '0;
  int          in_mode  = 0;   // 0 continuous, 1 toggle, 2 random
  int          out_mode = 0;   // 0 always ready, 1 stall unload cycles 3-6, 2 random
  int          fht_mode = 0;   // 0 normal, 1 RDY never falls, 2 RDY never rises
  int          fht_d1   = 2;
  int          fht_d2   = 100;

  // Sample RAM: 4 banks, 1-cycle read latency
  logic [15:0] mem [0:3][0:3];
  logic [15:0] rd_data;
  always @(posedge clk) begin
    if (bus.oWE) mem[bus.oBANK][bus.oADDR] <= in_data;
    rd_data <= mem[bus.oBANK][bus.oADDR];
  end

  // Input stream driver
  initial begin
    bus.iIN_VALID = 1'b0;
    forever begin
      @(posedge clk); #1;
      in_data = 16'($urandom);
      case (in_mode)
        0:       bus.iIN_VALID = 1'b1;
        1:       bus.iIN_VALID = ~bus.iIN_VALID;
        default: bus.iIN_VALID = ($urandom % 4) != 0;
      endcase
    end
  end

  // Output ready driver
  initial begin
    int ucyc;
    ucyc = 0;
    bus.iOUT_READY = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (out_mode)
        0:       bus.iOUT_READY = 1'b1;
        1:       bus.iOUT_READY = !(ucyc >= 3 && ucyc <= 6);
        default: bus.iOUT_READY = ($urandom % 3) != 0;
      endcase
      if (bus.oSEL == 2'd3) ucyc++;
      else ucyc = 0;
    end
  end

  // fht_control stand-in: RDY drops d1 cycles after start, rises d2 later
  initial begin
    bus.iFHT_RDY = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) bus.iFHT_RDY = 1'b1;
      else if (bus.oSTART && fht_mode != 1) begin
        int d1, d2;
        d1 = (fht_mode == 2) ? 1 : fht_d1;
        d2 = fht_d2;
        repeat (d1) @(posedge clk);
        #1 bus.iFHT_RDY = 1'b0;
        if (fht_mode == 0) begin
          repeat (d2) @(posedge clk);
          #1 bus.iFHT_RDY = 1'b1;
        end
      end
    end
  end

  // Scoreboard and monitor
  logic [15:0] exp_q[$];
  int load_k = 0;
  int out_k  = 0;
  int frames_done = 0;
  bit start_due = 0, start_gap = 0, busy_due = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      load_k = 0; out_k = 0;
      start_due = 0; start_gap = 0; busy_due = 0;
    end else begin
      if (start_due) begin
        check("start_after_load", {bus.oSTART, bus.oSEL}, {1'b1, 2'd2});
        start_due = 0; start_gap = 1;
      end else if (start_gap) begin
        check("start_one_cycle", bus.oSTART, 0);
        start_gap = 0;
      end
      if (busy_due) begin
        check("busy_after_frame", bus.oBUSY, 0);
        busy_due = 0;
      end
      if (bus.iIN_VALID && bus.oIN_READY) begin
        check("load_we", bus.oWE, 1);
        check("load_bank", bus.oBANK, load_k % 4);
        check("load_addr", bus.oADDR, load_k / 4);
        exp_q.push_back(in_data);
        if (load_k == N - 1) begin load_k = 0; start_due = 1; end
        else load_k++;
      end else if (bus.iIN_VALID) begin
        check("ignored_input_we", bus.oWE, 0);
      end
      if (bus.oOUT_VALID) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL out_spurious: valid with no expected word at %0t", $time);
        end else begin
          check("out_data", rd_data, exp_q[0]);
          if (!bus.iOUT_READY) begin
            check("stall_bank", bus.oBANK, out_k % 4);
            check("stall_addr", bus.oADDR, out_k / 4);
          end else begin
            void'(exp_q.pop_front());
            if (out_k == N - 1) begin out_k = 0; busy_due = 1; frames_done++; end
            else out_k++;
          end
        end
      end
    end
  end

  task automatic wait_frames(input int target, input int budget);
    int c;
    c = 0;
    while (frames_done < target && c < budget) begin @(negedge clk); c++; end
    check("frame_complete", frames_done, target);
  endtask

  task automatic wait_start(input int budget);
    int c;
    c = 0;
    while (!bus.oSTART && c < budget) begin @(negedge clk); c++; end
    check("start_seen", bus.oSTART, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("err_cleared_by_reset", bus.oERR, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset hold: every output low, input valid ignored
    in_mode = 0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.oIN_READY, bus.oSTART, bus.oSEL, bus.oBANK, bus.oADDR,
           bus.oWE, bus.oOUT_VALID, bus.oBUSY, bus.oERR}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_to_load", {bus.oBUSY, bus.oSEL, bus.oIN_READY}, {1'b1, 2'd1, 1'b1});

    // Continuous load, long FHT run, full-throughput unload
    fht_d1 = 2; fht_d2 = 100; out_mode = 0;
    wait_frames(1, 1000);

    // Gapped load with backpressure in the unload
    in_mode = 1; out_mode = 1; fht_d1 = 4; fht_d2 = 7;
    wait_frames(2, 1000);

    // Randomised frames
    for (int f = 3; f <= 6; f++) begin
      in_mode  = 2;
      out_mode = (f % 2 == 1) ? 2 : 1;
      fht_d1   = $urandom_range(1, 4);
      fht_d2   = $urandom_range(1, 20);
      wait_frames(f, 2000);
    end

    // RDY never falls: error five cycles after the start pulse, stuck in IDLE
    fht_mode = 1; in_mode = 0;
    wait_start(500);
    repeat (4) @(negedge clk);
    check("err_not_early", bus.oERR, 0);
    @(negedge clk);
    check("err_wait_busy", bus.oERR, 1);
    repeat (3) @(negedge clk);
    check("hold_idle_on_err", {bus.oBUSY, bus.oIN_READY, bus.oSEL}, 0);
    do_reset();

    // RDY falls but never rises: watchdog after 256 RUN cycles
    fht_mode = 2;
    wait_start(500);
    repeat (257) @(negedge clk);
    check("wd_not_early", bus.oERR, 0);
    @(negedge clk);
    check("wd_fired", bus.oERR, 1);
    do_reset();

    // Reset in the middle of a load; next frame restarts at sample 0
    fht_mode = 0; in_mode = 0; out_mode = 2; fht_d1 = 1; fht_d2 = 5;
    begin
      int c;
      c = 0;
      while (load_k != 7 && c < 500) begin @(negedge clk); #1; c++; end
      check("mid_load_reached", load_k, 7);
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_load_reset_idle", {bus.oBUSY, bus.oWE, bus.oSEL}, 0);
    rst_n = 1'b1;
    wait_frames(frames_done + 1, 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
